// File: rtl/do_burst_gen.sv
// do_burst_gen: command stage that drives a registered burst level
// to the downstream transfer FSM and waits for its LAST acknowledge.
module do_burst_gen #(
  parameter int LEN_W   = 8,
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  input  logic             ack,
  input  logic             err_clr,
  // the burst level is named do_o since `do` is a keyword
  output logic             do_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic             do_q, do_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      do_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      do_q    <= do_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    do_d    = do_q;
    done_d  = 1'b0;
    err_d   = err_q & ~err_clr;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gap_d   = gap_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          gap_d   = cmd_gap;
          do_d    = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        len_d = len_q - LEN_W'(1);
        if (abort || len_q == LEN_W'(1)) begin
          do_d    = 1'b0;
          to_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        do_d = 1'b0;
        // ack takes precedence over a timeout landing on the same edge
        if (ack || to_q == TO_LAST) begin
          done_d = 1'b1;
          if (ack) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          state_d = (gap_q == '0) ? S_IDLE : S_GAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign do_o      = do_q;
  assign done      = done_q;
  assign err       = err_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_do_burst_gen.sv
// tb_do_burst_gen: scoreboard bench with a downstream IDLE/RUN/LAST
// model looped back to ack and randomized burst commands.
module tb_do_burst_gen;

  localparam int LEN_W   = 8;
  localparam int GAP_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [GAP_W-1:0] cmd_gap;
  logic             abort;
  logic             ack;
  logic             err_clr;
  logic             do_o;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] burst_cnt;

  do_burst_gen #(
    .LEN_W(LEN_W),
    .GAP_W(GAP_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len(cmd_len),
    .cmd_gap(cmd_gap),
    .abort(abort),
    .ack(ack),
    .err_clr(err_clr),
    .do_o(do_o),
    .busy(busy),
    .done(done),
    .err(err),
    .burst_cnt(burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream transfer FSM: ack is its one-cycle LAST flag
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_LAST} ds_e;
  ds_e ds;
  logic ack_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds <= D_IDLE;
    else begin
      case (ds)
        D_IDLE:  if (do_o) ds <= D_RUN;
        D_RUN:   if (!do_o) ds <= D_LAST;
        default: ds <= D_IDLE;
      endcase
    end
  end

  assign ack = ack_en && (ds == D_LAST);

  typedef struct {
    int         len;
    int         lat;
    int         gap;
    logic [15:0] cnt;
    bit         err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [15:0] model_cnt;
  bit model_err;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // monitor: pops one expectation per done pulse
  int cyc = 0;
  int run = 0;
  int last_run = 0;
  int fall_cyc = 0;
  int gap_n = 0;
  bit prev_do = 0;
  bit gap_chk = 0;
  bit rise_chk = 0;
  exp_t cur;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      run = 0;
      prev_do = 0;
      gap_chk = 0;
      rise_chk = 0;
    end else begin
      if (rise_chk) begin
        chk("rise_after_gap", do_o, 1);
        rise_chk = 0;
      end
      if (do_o) run++;
      else if (prev_do) begin
        last_run = run;
        run = 0;
        fall_cyc = cyc;
      end
      prev_do = do_o;
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = sb.pop_front();
          chk("do_high_len", last_run, cur.len);
          chk("done_latency", cyc - fall_cyc, cur.lat);
          chk("burst_cnt", burst_cnt, cur.cnt);
          chk("err_at_done", err, cur.err);
          gap_chk = 1;
          gap_n = 0;
        end
      end
      if (gap_chk) begin
        if (cmd_ready) begin
          chk("gap_len", gap_n, cur.gap);
          gap_chk = 0;
          rise_chk = cmd_valid;
        end else if (gap_n > 40) begin
          chk("gap_stuck", gap_n, cur.gap);
          gap_chk = 0;
        end else gap_n++;
      end
    end
  end

  task automatic wait_accept();
    int n;
    bit r;
    n = 0;
    do begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 0, 1);
    #1;
    cmd_valid = 1'b0;
    cmd_len = LEN_W'($urandom);
    cmd_gap = GAP_W'($urandom);
  endtask

  task automatic run_cmd(int len, int gap, int ab, bit ack_on, bit clr_to);
    exp_t e;
    int eff;
    int n;
    @(posedge clk);
    #1;
    eff = (len == 0) ? 1 : len;
    ack_en = ack_on;
    e.len = (ab > 0 && ab < eff) ? ab : eff;
    e.lat = ack_on ? 2 : TIMEOUT;
    e.gap = gap;
    e.cnt = ack_on ? model_cnt + 16'd1 : model_cnt;
    e.err = ack_on ? model_err : 1'b1;
    model_cnt = e.cnt;
    if (!ack_on) model_err = 1'b1;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(len);
    cmd_gap = GAP_W'(gap);
    wait_accept();
    if (ab > 0) begin
      repeat (ab - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
    if (clr_to) begin
      n = 0;
      while (do_o && n < 300) begin
        @(negedge clk);
        n++;
      end
      repeat (TIMEOUT - 1) @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_wait_timeout", 0, 1);
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
  endtask

  initial begin
    int len;
    int eff;
    int ab;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_len = '0;
    cmd_gap = '0;
    abort = 1'b0;
    err_clr = 1'b0;
    ack_en = 1'b1;
    model_cnt = '0;
    model_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_do", do_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", burst_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    run_cmd(3, 0, 0, 1'b1, 1'b0);
    run_cmd(0, 0, 0, 1'b1, 1'b0);
    run_cmd(2, 0, 0, 1'b0, 1'b0);
    clear_err();
    run_cmd(2, 1, 0, 1'b0, 1'b1);
    clear_err();
    run_cmd(10, 0, 4, 1'b1, 1'b0);
    run_cmd(4, 5, 0, 1'b1, 1'b0);
    run_cmd(2, 5, 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 12);
      eff = (len == 0) ? 1 : len;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, eff + 1) : 0;
      run_cmd(len, $urandom_range(0, 3), ab,
              ($urandom_range(0, 9) != 0), 1'b0);
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    // asynchronous reset in the middle of a long drive phase
    @(posedge clk);
    #1;
    ack_en = 1'b1;
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(8);
    cmd_gap = '0;
    wait_accept();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_do", do_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", burst_cnt, 0);
    chk("arst_ready", cmd_ready, 1);
    model_cnt = '0;
    model_err = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cmd(5, 0, 0, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
